result_display: RTL

- Downstream stage of the 4:1 8-bit result selector.
- Captures the selected 8-bit result `Y` on a load strobe and converts it to three BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto the board's 4-digit common-anode seven-segment display.
- Sits between the ALU result path and the top-level FPGA pins.

---
 rtl/alu_disp_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 30 +++
 rtl/result_display.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the result display path: converter FSM states
// and active-low seven-segment glyphs.
package alu_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_COUNT = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segments; codes above 9 and the
// blank flag both produce a dark digit.
module seg7_decode
    import alu_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display.sv
// Captures an 8-bit result, converts it to BCD with a one-bit-per-cycle
// double-dabble engine, and scans it onto a 4-digit common-anode display.
module result_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value_in,
    input  logic       load,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    state_t                  state;
    logic [19:0]             sr;
    logic [2:0]              bit_cnt;
    logic [3:0]              hund;
    logic [3:0]              tens;
    logic [3:0]              units;
    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]              sel;
    logic [3:0]              dig_bcd;
    logic                    dig_blank;
    logic [6:0]              dig_seg;

    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5)
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    // Converter control; load is only honoured from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= 3'd0;
            hund    <= 4'd0;
            tens    <= 4'd0;
            units   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state   <= CONV;
                        busy    <= 1'b1;
                        bit_cnt <= 3'd0;
                    end
                end
                CONV: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state <= DONE;
                end
                DONE: begin
                    hund  <= sr[19:16];
                    tens  <= sr[15:12];
                    units <= sr[11:8];
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Shift register is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && load)
            sr <= {12'h000, value_in};
        else if (state == CONV)
            sr <= dabble_step(sr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            refresh <= '0;
        else
            refresh <= refresh + 1'b1;
    end

    assign sel = refresh[REFRESH_BITS-1 -: 2];

    always_comb begin
        dig_bcd   = 4'd0;
        dig_blank = 1'b1;
        case (sel)
            2'd0: begin
                dig_bcd   = units;
                dig_blank = 1'b0;
            end
            2'd1: begin
                dig_bcd   = tens;
                dig_blank = BLANK_LZ && (hund == 4'd0) && (tens == 4'd0);
            end
            2'd2: begin
                dig_bcd   = hund;
                dig_blank = BLANK_LZ && (hund == 4'd0);
            end
            default: begin
                dig_bcd   = 4'd0;
                dig_blank = 1'b1;
            end
        endcase
    end

    seg7_decode u_decode (
        .bcd   (dig_bcd),
        .blank (dig_blank),
        .seg   (dig_seg)
    );

    // Output stage: anode and segments change together, one cycle after sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << sel);
            seg <= dig_seg;
        end
    end

    assign dp = 1'b1;

endmodule
